mem_port_arbiter: RTL and testbench

// - Shares one single-port unified memory between the fetch stage (IF) and the load/store path (D).
// - Sits between fetch/memory stages and the memory model.
// - Per-cycle grant with fixed-latency read return; read data routed back by owner tag.
// - Flushes in-flight fetch responses on redirect (pcsel / branch taken).

---
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch (IF) and load/store (D), with a
// fixed-latency owner-tag return path and IF flush. Optional stall counters: MEM_ARB_STATS_EN.
module mem_port_arbiter #(
    parameter int AWIDTH     = 32,
    parameter int DWIDTH     = 32,
    parameter int LATENCY    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_i,
    input  logic [AWIDTH-1:0]     if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [DWIDTH-1:0]     if_rdata_o,
    input  logic                  flush_i,
    input  logic                  d_req_i,
    input  logic                  d_we_i,
    input  logic [AWIDTH-1:0]     d_addr_i,
    input  logic [DWIDTH-1:0]     d_wdata_i,
    input  logic [DWIDTH/8-1:0]   d_be_i,
    output logic                  d_gnt_o,
    output logic                  d_rvalid_o,
    output logic [DWIDTH-1:0]     d_rdata_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [AWIDTH-1:0]     mem_addr_o,
    output logic [DWIDTH-1:0]     mem_wdata_o,
    output logic [DWIDTH/8-1:0]   mem_be_o,
`ifdef MEM_ARB_STATS_EN
    output logic [31:0]           stat_if_stall_o,
    output logic [31:0]           stat_d_stall_o,
`endif
    input  logic [DWIDTH-1:0]     mem_rdata_i
);

    localparam int BEW = DWIDTH / 8;
    localparam int SCW = $clog2(STARVE_MAX + 1);
    localparam logic [SCW-1:0] STARVE_LIM = SCW'(STARVE_MAX);

    logic [SCW-1:0]     r_starve_cnt;
    logic [SCW-1:0]     w_starve_nxt;
    logic [LATENCY-1:0] r_tag_vld;
    logic [LATENCY-1:0] r_tag_if;
    logic [LATENCY-1:0] w_tag_vld_nxt;
    logic [LATENCY-1:0] w_tag_if_nxt;
    logic               w_if_cand;
    logic               w_d_cand;
    logic               w_if_gnt;
    logic               w_d_gnt;

    // Nothing is granted while reset is held; a flushed fetch never competes.
    assign w_if_cand = rst & if_req_i & ~flush_i;
    assign w_d_cand  = rst & d_req_i;
    assign w_if_gnt  = w_if_cand & (~w_d_cand | (r_starve_cnt == STARVE_LIM));
    assign w_d_gnt   = w_d_cand & ~w_if_gnt;

    assign if_gnt_o  = w_if_gnt;
    assign d_gnt_o   = w_d_gnt;

    // Memory-side request mux driven by the single winner of this cycle.
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = {AWIDTH{1'b0}};
        mem_wdata_o = {DWIDTH{1'b0}};
        mem_be_o    = {BEW{1'b0}};
        if (w_d_gnt) begin
            mem_req_o   = 1'b1;
            mem_we_o    = d_we_i;
            mem_addr_o  = d_addr_i;
            mem_wdata_o = d_wdata_i;
            mem_be_o    = d_we_i ? d_be_i : {BEW{1'b1}};
        end else if (w_if_gnt) begin
            mem_req_o   = 1'b1;
            mem_addr_o  = if_addr_i;
            mem_be_o    = {BEW{1'b1}};
        end else begin
            mem_req_o   = 1'b0;
        end
    end

    // Starvation counter: a flushed request neither ages nor resets the counter.
    always_comb begin
        w_starve_nxt = r_starve_cnt;
        if (!if_req_i || w_if_gnt) begin
            w_starve_nxt = {SCW{1'b0}};
        end else if (!flush_i && (r_starve_cnt != STARVE_LIM)) begin
            w_starve_nxt = r_starve_cnt + {{(SCW-1){1'b0}}, 1'b1};
        end else begin
            w_starve_nxt = r_starve_cnt;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve_cnt <= {SCW{1'b0}};
        end else begin
            r_starve_cnt <= w_starve_nxt;
        end
    end

    // Tag shift: stage 0 captures read grants, flush kills IF-owned entries as they move.
    always_comb begin
        w_tag_vld_nxt    = {LATENCY{1'b0}};
        w_tag_if_nxt     = {LATENCY{1'b0}};
        w_tag_vld_nxt[0] = w_if_gnt | (w_d_gnt & ~d_we_i);
        w_tag_if_nxt[0]  = w_if_gnt;
        for (int i = 1; i < LATENCY; i++) begin
            w_tag_vld_nxt[i] = r_tag_vld[i-1] & ~(flush_i & r_tag_if[i-1]);
            w_tag_if_nxt[i]  = r_tag_if[i-1];
        end
    end

    // Tag pipeline registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tag_vld <= {LATENCY{1'b0}};
            r_tag_if  <= {LATENCY{1'b0}};
        end else begin
            r_tag_vld <= w_tag_vld_nxt;
            r_tag_if  <= w_tag_if_nxt;
        end
    end

    assign if_rvalid_o = r_tag_vld[LATENCY-1] & r_tag_if[LATENCY-1] & ~flush_i;
    assign d_rvalid_o  = r_tag_vld[LATENCY-1] & ~r_tag_if[LATENCY-1];
    assign if_rdata_o  = mem_rdata_i;
    assign d_rdata_o   = mem_rdata_i;

`ifdef MEM_ARB_STATS_EN
    logic [31:0] r_if_stall;
    logic [31:0] r_d_stall;

    // Saturating per-requester stall counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_if_stall <= 32'd0;
            r_d_stall  <= 32'd0;
        end else begin
            if (if_req_i && !w_if_gnt && (r_if_stall != 32'hFFFF_FFFF)) begin
                r_if_stall <= r_if_stall + 32'd1;
            end
            if (d_req_i && !w_d_gnt && (r_d_stall != 32'hFFFF_FFFF)) begin
                r_d_stall <= r_d_stall + 32'd1;
            end
        end
    end

    assign stat_if_stall_o = r_if_stall;
    assign stat_d_stall_o  = r_d_stall;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: grant vector table, directed latency/flush/
// starvation/reset sequences, and randomized traffic against a queue-based reference model.
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int LAT  = 2;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_req_i = 1'b0, flush_i = 1'b0, d_req_i = 1'b0, d_we_i = 1'b0;
    logic [AW-1:0] if_addr_i = '0, d_addr_i = '0;
    logic [DW-1:0] d_wdata_i = '0, mem_rdata_i = '0;
    logic [3:0]    d_be_i = '0;
    logic          if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o, mem_req_o, mem_we_o;
    logic [DW-1:0] if_rdata_o, d_rdata_o, mem_wdata_o;
    logic [AW-1:0] mem_addr_o;
    logic [3:0]    mem_be_o;

    mem_port_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .LATENCY(LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .flush_i(flush_i),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_be_i(d_be_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int m_starve = 0;
    int q_due[$];
    bit q_if[$];
    logic o_if_gnt, o_d_gnt, o_if_rv, o_d_rv, o_mwe;
    logic [3:0] o_mbe;

    typedef struct {
        logic ir, fl, dr, dw;
        logic [3:0] be;
        logic eig, edg, emr, emw;
        logic [3:0] ebe;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h cyc=%0d", nm, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, predict from the arbitration rules, compare, advance model.
    task automatic step(input logic ir, input logic [31:0] ia, input logic fl, input logic dr,
                        input logic dw, input logic [31:0] da, input logic [31:0] dd,
                        input logic [3:0] be, input logic [31:0] rd);
        logic xi, xd, xrvi, xrvd;
        logic [31:0] xa, xw;
        logic [3:0] xb;
        int nd[$];
        bit ni[$];
        @(posedge clk); #1;
        if_req_i = ir; if_addr_i = ia; flush_i = fl; d_req_i = dr; d_we_i = dw;
        d_addr_i = da; d_wdata_i = dd; d_be_i = be; mem_rdata_i = rd;
        cyc++;
        xi = 1'b0; xd = 1'b0;
        if (ir && !fl && (!dr || m_starve >= SMAX)) xi = 1'b1;
        else if (dr) xd = 1'b1;
        xa = xi ? ia : (xd ? da : 32'd0);
        xw = xd ? dd : 32'd0;
        xb = xi ? 4'hF : (xd ? (dw ? be : 4'hF) : 4'h0);
        xrvi = 1'b0; xrvd = 1'b0;
        if (q_due.size() > 0 && q_due[0] == cyc) begin
            if (q_if[0]) xrvi = !fl;
            else xrvd = 1'b1;
            void'(q_due.pop_front());
            void'(q_if.pop_front());
        end
        #2;
        chk("if_gnt", if_gnt_o, xi);
        chk("d_gnt", d_gnt_o, xd);
        chk("mem_req", mem_req_o, xi | xd);
        chk("mem_we", mem_we_o, xd & dw);
        chk("mem_addr", mem_addr_o, xa);
        chk("mem_wdata", mem_wdata_o, xw);
        chk("mem_be", mem_be_o, xb);
        chk("if_rvalid", if_rvalid_o, xrvi);
        chk("d_rvalid", d_rvalid_o, xrvd);
        if (xrvi) chk("if_rdata", if_rdata_o, rd);
        if (xrvd) chk("d_rdata", d_rdata_o, rd);
        o_if_gnt = if_gnt_o; o_d_gnt = d_gnt_o; o_if_rv = if_rvalid_o;
        o_d_rv = d_rvalid_o; o_mwe = mem_we_o; o_mbe = mem_be_o;
        if (fl) begin
            foreach (q_due[k]) if (!q_if[k]) begin nd.push_back(q_due[k]); ni.push_back(1'b0); end
            q_due = nd; q_if = ni;
        end
        if (xi || (xd && !dw)) begin q_due.push_back(cyc + LAT); q_if.push_back(xi); end
        if (!ir || xi) m_starve = 0;
        else if (!fl && m_starve < SMAX) m_starve++;
    endtask

    task automatic idle(input logic [31:0] rd);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0, rd);
    endtask

    initial begin
        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 4'hF};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h3, 1'b0, 1'b1, 1'b1, 1'b0, 4'hF};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'h3, 1'b0, 1'b1, 1'b1, 1'b1, 4'h3};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 4'hF};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'h5, 1'b0, 1'b1, 1'b1, 1'b1, 4'h5};

        // Requests held during reset must not be granted.
        if_req_i = 1'b1; d_req_i = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_if_gnt", if_gnt_o, 1'b0);
        chk("rst_d_gnt", d_gnt_o, 1'b0);
        chk("rst_mem_req", mem_req_o, 1'b0);
        chk("rst_rvalid", {if_rvalid_o, d_rvalid_o}, 2'b00);
        @(posedge clk); #1;
        rst = 1'b1; if_req_i = 1'b0; d_req_i = 1'b0;

        for (int i = 0; i < 7; i++) begin
            step(tbl[i].ir, 32'h1000 + i, tbl[i].fl, tbl[i].dr, tbl[i].dw,
                 32'h2000 + i, 32'hA500 + i, tbl[i].be, 32'd0);
            chk("tbl_if_gnt", o_if_gnt, tbl[i].eig);
            chk("tbl_d_gnt", o_d_gnt, tbl[i].edg);
            chk("tbl_mem_we", o_mwe, tbl[i].emw);
            chk("tbl_mem_be", o_mbe, tbl[i].ebe);
            repeat (LAT) idle(32'h0);
        end

        // IF-only load at 0x100, data back LATENCY cycles later.
        step(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0, 32'd0);
        chk("if_only_gnt", o_if_gnt, 1'b1);
        idle(32'h0);
        idle(32'h1234_5678);
        chk("if_only_rvalid", o_if_rv, 1'b1);

        // Starvation: D wins four times, IF forced on the fifth.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 32'h300 + i, 1'b0, 1'b1, 1'b0, 32'h400 + i, 32'd0, 4'h0, 32'd0);
            chk("starve_d_gnt", o_d_gnt, (i != 4));
            chk("starve_if_gnt", o_if_gnt, (i == 4));
        end
        repeat (LAT + 1) idle(32'h0);

        // Flush kills the in-flight fetch, D load behind it still returns.
        step(1'b1, 32'h500, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0, 32'd0);
        step(1'b1, 32'h504, 1'b1, 1'b1, 1'b0, 32'h600, 32'd0, 4'h0, 32'd0);
        chk("flush_d_gnt", o_d_gnt, 1'b1);
        idle(32'hCAFE_0001);
        chk("flush_if_rvalid", o_if_rv, 1'b0);
        idle(32'hCAFE_0002);
        chk("flush_d_rvalid", o_d_rv, 1'b1);

        // Store: byte enables pass through, no response ever.
        step(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, 4'b0011, 32'd0);
        chk("store_we", o_mwe, 1'b1);
        chk("store_be", o_mbe, 4'b0011);
        repeat (LAT + 1) begin
            idle(32'h0);
            chk("store_no_rvalid", o_d_rv, 1'b0);
        end

        // Back-to-back IF, D, IF reads.
        step(1'b1, 32'h700, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0, 32'd0);
        step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'h800, 32'd0, 4'h0, 32'd0);
        step(1'b1, 32'h704, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0, 32'h0000_0A01);
        chk("b2b_if_rv0", o_if_rv, 1'b1);
        idle(32'h0000_0A02);
        chk("b2b_d_rv", o_d_rv, 1'b1);
        idle(32'h0000_0A03);
        chk("b2b_if_rv1", o_if_rv, 1'b1);
        repeat (LAT) idle(32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom,
                 $urandom, 4'($urandom), $urandom);
        end
        repeat (LAT) idle(32'h0);

        // Reset with two reads in flight.
        step(1'b1, 32'h900, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0, 32'd0);
        step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'h904, 32'd0, 4'h0, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; if_req_i = 1'b1; d_req_i = 1'b1; if_addr_i = 32'h908;
        #1;
        chk("arst_if_gnt", if_gnt_o, 1'b0);
        chk("arst_d_gnt", d_gnt_o, 1'b0);
        chk("arst_mem_req", mem_req_o, 1'b0);
        chk("arst_mem_addr", mem_addr_o, 32'd0);
        chk("arst_rvalid", {if_rvalid_o, d_rvalid_o}, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1; if_req_i = 1'b0; d_req_i = 1'b0;
        q_due.delete(); q_if.delete(); m_starve = 0;
        repeat (2 * LAT) begin
            idle(32'h0);
            chk("post_rst_rvalid", {o_if_rv, o_d_rv}, 2'b00);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
